// File: rtl/keypad_entry_buffer_pkg.sv
// Shared types and constants for the keypad entry buffer: key indices, FSM states,
// 7-segment patterns and the binary-width helper.
package keypad_pkg;

    typedef logic [3:0] bcd_t;

    localparam int KEY_BKSP  = 10;
    localparam int KEY_CLR   = 11;
    localparam int KEY_ENTER = 12;
    localparam int NUM_KEYS  = 13;

    typedef enum logic [1:0] {IDLE, CONVERT, HOLD} state_t;

    // Active-low segments, bit 0 = a .. bit 6 = g; entry 10 is the blank pattern.
    localparam int SEG_BLANK = 10;
    localparam logic [10:0][6:0] SEG_LUT = {
        7'h7F, 7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
        7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic logic [6:0] seg7(input bcd_t d);
        return (d <= 4'd9) ? SEG_LUT[d] : SEG_LUT[SEG_BLANK];
    endfunction

    // Bits needed to hold any n-digit decimal value.
    function automatic int val_w(input int n);
        longint p;
        p = 1;
        for (int i = 0; i < n; i++) p = p * 64'd10;
        return $clog2(p);
    endfunction

endpackage

// File: rtl/keypad_entry_buffer_if.sv
// Output-side bundle of the keypad entry buffer: entry state, converted value and its
// valid/ready handshake. seg_o exists only when KEYPAD_SEG_EN is defined.
interface keypad_entry_buffer_if import keypad_pkg::*; #(
    parameter int NUM_DIGITS = 4
);
    localparam int VAL_W = val_w(NUM_DIGITS);
    localparam int CNT_W = $clog2(NUM_DIGITS + 1);

    logic [4*NUM_DIGITS-1:0] digits_o;
    logic [CNT_W-1:0]        count_o;
    logic                    overflow_o;
    logic [VAL_W-1:0]        value_o;
    logic                    valid_o;
    logic                    ready_i;
    logic                    busy_o;
`ifdef KEYPAD_SEG_EN
    logic [7*NUM_DIGITS-1:0] seg_o;
`endif

    modport master (
`ifdef KEYPAD_SEG_EN
        output seg_o,
`endif
        output digits_o, count_o, overflow_o, value_o, valid_o, busy_o,
        input  ready_i
    );

    modport slave (
`ifdef KEYPAD_SEG_EN
        input  seg_o,
`endif
        input  digits_o, count_o, overflow_o, value_o, valid_o, busy_o,
        output ready_i
    );

endinterface

// File: rtl/keypad_key_filter.sv
// Synchronises and debounces the 13 raw keys, then emits a one-cycle strobe with the
// key code when the accepted vector goes from all-zero to exactly one key.
module keypad_key_filter import keypad_pkg::*; #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] keys,
    output logic                evt_o,
    output logic [3:0]          code_o
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    logic [NUM_KEYS-1:0] sync1, sync2, cand, stable;
    logic [CNT_W-1:0]    cnt;
    logic                armed;
    logic                single;
    logic [3:0]          enc;

    assign single = (stable != '0) && ((stable & (stable - 1'b1)) == '0);

    always_comb begin
        enc = '0;
        for (int i = 0; i < NUM_KEYS; i++)
            if (stable[i]) enc = 4'(i);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1  <= '0;
            sync2  <= '0;
            cand   <= '0;
            stable <= '0;
            cnt    <= '0;
            armed  <= 1'b0;
            evt_o  <= 1'b0;
            code_o <= '0;
        end else begin
            sync1 <= keys;
            sync2 <= sync1;
            // cnt is the run length of identical samples; accept on the Nth.
            if (sync2 != cand) begin
                cand <= sync2;
                cnt  <= CNT_W'(1);
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
                if (cnt == CNT_MAX - 1'b1) stable <= cand;
            end
            // armed = accepted vector was all-zero last cycle, so only a direct
            // zero-to-one-hot transition fires and held keys never repeat.
            armed  <= (stable == '0);
            evt_o  <= armed && single;
            code_o <= enc;
        end
    end

endmodule

// File: rtl/keypad_entry_buffer.sv
// Keypad entry buffer: BCD digit entry with backspace/clear, Horner conversion to
// binary on enter, result on a valid/ready port. Define KEYPAD_SEG_EN for seg_o.
module keypad_entry_buffer import keypad_pkg::*; #(
    parameter int NUM_DIGITS      = 4,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] key_digit,
    input  logic       key_bksp,
    input  logic       key_clr,
    input  logic       key_enter,
    keypad_entry_buffer_if.master bus
);
    localparam int VAL_W = val_w(NUM_DIGITS);
    localparam int CNT_W = $clog2(NUM_DIGITS + 1);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic       evt;
    logic [3:0] code;

    keypad_key_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_filter (
        .clk    (clk),
        .reset  (reset),
        .keys   ({key_enter, key_clr, key_bksp, key_digit}),
        .evt_o  (evt),
        .code_o (code)
    );

    bcd_t [NUM_DIGITS-1:0] ent_q, conv_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  ovf_q;
    state_t                state_q, state_n;
    logic [IDX_W-1:0]      idx_q;
    logic [VAL_W-1:0]      acc_q, val_q, acc_nx;

    logic is_digit, is_bksp, is_clr, enter_go;
    assign is_digit = evt && (code <= 4'd9);
    assign is_bksp  = evt && (code == 4'(KEY_BKSP));
    assign is_clr   = evt && (code == 4'(KEY_CLR));
    assign enter_go = evt && (code == 4'(KEY_ENTER)) && (state_q == IDLE);

    // Widened concatenations keep the shifts legal for a single-digit buffer.
    logic [4*NUM_DIGITS+3:0] up_w, dn_w;
    assign up_w = {ent_q, code};
    assign dn_w = {4'h0, ent_q};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ent_q  <= '0;
            conv_q <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            ovf_q <= 1'b0;
            if (enter_go) begin
                conv_q <= ent_q;
                ent_q  <= '0;
                cnt_q  <= '0;
            end else if (is_digit) begin
                if (cnt_q != CNT_W'(NUM_DIGITS)) begin
                    ent_q <= up_w[4*NUM_DIGITS-1:0];
                    cnt_q <= cnt_q + 1'b1;
                end else begin
                    ovf_q <= 1'b1;
                end
            end else if (is_bksp && (cnt_q != '0)) begin
                ent_q <= dn_w[4*NUM_DIGITS+3:4];
                cnt_q <= cnt_q - 1'b1;
            end else if (is_clr) begin
                ent_q <= '0;
                cnt_q <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_n;
    end

    always_comb begin
        state_n = state_q;
        case (state_q)
            IDLE:    if (enter_go) state_n = CONVERT;
            CONVERT: if (idx_q == '0) state_n = HOLD;
            HOLD:    if (bus.ready_i) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Horner step, most significant snapshot digit first; the result always fits VAL_W.
    assign acc_nx = acc_q * VAL_W'(10) + VAL_W'(conv_q[idx_q]);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_q <= '0;
            acc_q <= '0;
            val_q <= '0;
        end else if (enter_go) begin
            idx_q <= IDX_W'(NUM_DIGITS - 1);
            acc_q <= '0;
        end else if (state_q == CONVERT) begin
            acc_q <= acc_nx;
            idx_q <= idx_q - 1'b1;
            if (idx_q == '0) val_q <= acc_nx;
        end
    end

    assign bus.digits_o   = ent_q;
    assign bus.count_o    = cnt_q;
    assign bus.overflow_o = ovf_q;
    assign bus.value_o    = val_q;
    assign bus.valid_o    = (state_q == HOLD);
    assign bus.busy_o     = (state_q == CONVERT);

`ifdef KEYPAD_SEG_EN
    logic [NUM_DIGITS-1:0][6:0] seg_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seg_q <= {NUM_DIGITS{SEG_LUT[SEG_BLANK]}};
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++)
                seg_q[i] <= (CNT_W'(i) < cnt_q) ? seg7(ent_q[i]) : SEG_LUT[SEG_BLANK];
        end
    end

    assign bus.seg_o = seg_q;
`endif

endmodule

// File: tb/tb_keypad_entry_buffer.sv
// Scoreboard bench for keypad_entry_buffer: stimulus queues expected buffer updates
// and converted values; a negedge monitor pops and compares as the DUT presents them.
module tb_keypad_entry_buffer;

    localparam int ND = 4;
    localparam int DB = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [12:0] kv = '0;

    always #5 clk = ~clk;

    keypad_entry_buffer_if #(.NUM_DIGITS(ND)) bus();

    keypad_entry_buffer #(.NUM_DIGITS(ND), .DEBOUNCE_CYCLES(DB)) dut (
        .clk       (clk),
        .reset     (reset),
        .key_digit (kv[9:0]),
        .key_bksp  (kv[10]),
        .key_clr   (kv[11]),
        .key_enter (kv[12]),
        .bus       (bus)
    );

    typedef struct {
        logic [15:0] d;
        int          c;
        bit          ovf;
    } bexp_t;

    bexp_t exp_buf[$];
    int    exp_val[$];
    int    total = 0;
    int    bad = 0;
    int    busy_cnt = 0, valid_cnt = 0, ovf_cnt = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, got, got, want, want);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input int k);
        kv[k] = 1'b1;
        cyc(DB + 6);
        kv[k] = 1'b0;
        cyc(DB + 6);
    endtask

    task automatic pushb(input logic [15:0] d, input int c, input bit o);
        bexp_t e;
        e.d = d; e.c = c; e.ovf = o;
        exp_buf.push_back(e);
    endtask

    // Monitor: any change of digits/count, or an overflow pulse, consumes one expected
    // buffer entry; every valid&&ready cycle consumes one expected value.
    initial begin
        logic [15:0] pd;
        int          pc;
        bexp_t       e;
        pd = '0; pc = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                pd = bus.digits_o;
                pc = int'(bus.count_o);
            end else begin
                if (bus.busy_o)     busy_cnt++;
                if (bus.valid_o)    valid_cnt++;
                if (bus.overflow_o) ovf_cnt++;
                if (bus.digits_o !== pd || int'(bus.count_o) != pc || bus.overflow_o) begin
                    if (exp_buf.size() == 0) begin
                        total++; bad++;
                        $display("FAIL buf_unexpected: digits=0x%0h count=%0d ovf=%0b",
                                 bus.digits_o, bus.count_o, bus.overflow_o);
                    end else begin
                        e = exp_buf.pop_front();
                        chk("buf_digits", bus.digits_o, e.d);
                        chk("buf_count", bus.count_o, e.c);
                        chk("buf_ovf", bus.overflow_o, e.ovf);
                    end
                    pd = bus.digits_o;
                    pc = int'(bus.count_o);
                end
                if (bus.valid_o && bus.ready_i) begin
                    if (exp_val.size() == 0) begin
                        total++; bad++;
                        $display("FAIL value_unexpected: value=%0d", bus.value_o);
                    end else begin
                        chk("value", bus.value_o, exp_val.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int  b0, v0, o0;
        bit  seen;
        bus.ready_i = 1'b1;
        cyc(3);
        chk("rst_digits", bus.digits_o, 0);
        chk("rst_count", bus.count_o, 0);
        chk("rst_ovf", bus.overflow_o, 0);
        chk("rst_value", bus.value_o, 0);
        chk("rst_valid", bus.valid_o, 0);
        chk("rst_busy", bus.busy_o, 0);
        reset = 1'b1;
        cyc(DB + 4);

        // 1,2,3,4 then enter with ready held high
        pushb(16'h0001, 1, 0); press(1);
        pushb(16'h0012, 2, 0); press(2);
        pushb(16'h0123, 3, 0); press(3);
        pushb(16'h1234, 4, 0); press(4);
        chk("t1_digits", bus.digits_o, 16'h1234);
        chk("t1_count", bus.count_o, 4);
        b0 = busy_cnt; v0 = valid_cnt;
        exp_val.push_back(1234);
        pushb(16'h0000, 0, 0); press(12);
        cyc(10);
        chk("t1_busy_cycles", busy_cnt - b0, 4);
        chk("t1_valid_cycles", valid_cnt - v0, 1);

        // short press and bounce must not register
        kv[5] = 1'b1; cyc(DB - 1); kv[5] = 1'b0; cyc(DB + 6);
        for (int i = 0; i < 6; i++) begin
            kv[5] = ~kv[5]; cyc(1);
        end
        kv[5] = 1'b0; cyc(DB + 6);
        chk("t2_bounce_count", bus.count_o, 0);
        pushb(16'h0005, 1, 0); press(5);
        chk("t2_count", bus.count_o, 1);

        // two keys at once are ignored
        pushb(16'h0000, 0, 0); press(11);
        kv[3] = 1'b1; kv[7] = 1'b1; cyc(DB + 6);
        kv[3] = 1'b0; kv[7] = 1'b0; cyc(DB + 6);
        chk("t3_combo_count", bus.count_o, 0);
        chk("t3_combo_digits", bus.digits_o, 0);
        pushb(16'h0009, 1, 0); press(9);
        chk("t3_count", bus.count_o, 1);
        chk("t3_digit0", bus.digits_o[3:0], 9);

        // overflow, backspace, clear
        pushb(16'h0000, 0, 0); press(11);
        pushb(16'h0009, 1, 0); press(9);
        pushb(16'h0099, 2, 0); press(9);
        pushb(16'h0999, 3, 0); press(9);
        pushb(16'h9999, 4, 0); press(9);
        o0 = ovf_cnt;
        pushb(16'h9999, 4, 1); press(1);
        chk("t4_ovf_cycles", ovf_cnt - o0, 1);
        chk("t4_digits", bus.digits_o, 16'h9999);
        pushb(16'h0999, 3, 0); press(10);
        pushb(16'h0099, 2, 0); press(10);
        chk("t4_bksp_digits", bus.digits_o, 16'h0099);
        pushb(16'h0000, 0, 0); press(11);
        chk("t4_clr_count", bus.count_o, 0);

        // back-pressure: result held, second enter dropped
        bus.ready_i = 1'b0;
        pushb(16'h0004, 1, 0); press(4);
        pushb(16'h0042, 2, 0); press(2);
        exp_val.push_back(42);
        pushb(16'h0000, 0, 0); press(12);
        chk("t5_valid_held", bus.valid_o, 1);
        chk("t5_value", bus.value_o, 42);
        pushb(16'h0007, 1, 0); press(7);
        press(12);
        chk("t5_valid_after_drop", bus.valid_o, 1);
        chk("t5_value_after_drop", bus.value_o, 42);
        chk("t5_digits_kept", bus.digits_o, 16'h0007);
        chk("t5_count_kept", bus.count_o, 1);
        bus.ready_i = 1'b1;
        cyc(1);
        chk("t5_valid_dropped", bus.valid_o, 0);
        chk("t5_value_holds", bus.value_o, 42);

        // reset in the middle of a conversion
        v0 = valid_cnt;
        pushb(16'h0000, 0, 0);
        kv[12] = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < DB + 20; i++) begin
            @(negedge clk);
            if (bus.busy_o) begin
                seen = 1'b1;
                break;
            end
        end
        chk("t6_busy_seen", seen, 1);
        #2 reset = 1'b0;
        #1;
        chk("t6_rst_busy", bus.busy_o, 0);
        chk("t6_rst_valid", bus.valid_o, 0);
        chk("t6_rst_value", bus.value_o, 0);
        chk("t6_rst_digits", bus.digits_o, 0);
        chk("t6_rst_count", bus.count_o, 0);
        chk("t6_rst_ovf", bus.overflow_o, 0);
        kv[12] = 1'b0;
        cyc(5);
        reset = 1'b1;
        cyc(DB + 15);
        chk("t6_no_valid", valid_cnt - v0, 0);
        chk("t6_idle_busy", bus.busy_o, 0);

        chk("buf_queue_left", exp_buf.size(), 0);
        chk("val_queue_left", exp_val.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
